// File: rtl/q15_pkg.sv
// Shared Q15 fixed-point encoding: 64-bit signed, 48 fractional bits, with
// reserved bit patterns for NaN and +/-inf.
package q15_pkg;
  localparam int Q15_W    = 64;
  localparam int Q15_FRAC = 48;

  localparam logic [Q15_W-1:0] Q15_NAN     = 64'h8000_0000_0000_0000;
  localparam logic [Q15_W-1:0] Q15_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [Q15_W-1:0] Q15_NEG_INF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [Q15_W-1:0] Q15_ONE     = 64'h0001_0000_0000_0000;

  typedef enum logic [1:0] {FINITE, NAN, POS_INF, NEG_INF} q15_class_t;

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
  } q15_flags_t;

  function automatic q15_class_t q15_classify(input logic [Q15_W-1:0] v);
    if (v == Q15_NAN)          return NAN;
    else if (v == Q15_POS_INF) return POS_INF;
    else if (v == Q15_NEG_INF) return NEG_INF;
    else                       return FINITE;
  endfunction
endpackage

// File: rtl/q15_sat_adder.sv
// Combinational single-term step: classify the term, add finite values and
// fold specials and overflow into the sticky flags.
module q15_sat_adder
  import q15_pkg::*;
(
  input  logic [Q15_W-1:0] acc,
  input  logic [Q15_W-1:0] term,
  input  q15_flags_t       flags_in,
  output logic [Q15_W-1:0] acc_next,
  output q15_flags_t       flags_next
);
  logic [Q15_W:0] sum;

  assign sum = {acc[Q15_W-1], acc} + {term[Q15_W-1], term};

  always_comb begin
    acc_next   = acc;
    flags_next = flags_in;
    unique case (q15_classify(term))
      NAN:     flags_next.nan  = 1'b1;
      POS_INF: flags_next.pinf = 1'b1;
      NEG_INF: flags_next.ninf = 1'b1;
      default: begin
        // On overflow the accumulator keeps its prior value; the sticky
        // flag alone decides the group's result from here on.
        if (sum[Q15_W] != sum[Q15_W-1]) begin
          if (sum[Q15_W]) flags_next.ninf = 1'b1;
          else            flags_next.pinf = 1'b1;
        end else begin
          acc_next = sum[Q15_W-1:0];
        end
      end
    endcase
  end
endmodule

// File: rtl/q15_dot_accumulator.sv
// Sums TERMS consecutive Q15 products per group and holds one saturating,
// special-aware result under a valid/ready handshake.
module q15_dot_accumulator
  import q15_pkg::*;
#(
  parameter int TERMS = 3,
  parameter int CNT_W = $clog2(TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q15_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q15_W-1:0] out_data,
  output logic             out_nan,
  output logic             out_inf
);
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [Q15_W-1:0] acc_q, acc_d, base_acc, add_acc, out_data_d;
  q15_flags_t       flags_q, flags_d, base_flags, add_flags;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_nan_d, out_inf_d, in_fire, out_fire;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // A term accepted while a result is being handed off opens a fresh group.
  assign base_acc   = out_valid ? '0 : acc_q;
  assign base_flags = out_valid ? '0 : flags_q;

  q15_sat_adder u_add (
    .acc        (base_acc),
    .term       (in_data),
    .flags_in   (base_flags),
    .acc_next   (add_acc),
    .flags_next (add_flags)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    flags_d    = flags_q;
    count_d    = count_q;
    out_data_d = out_data;
    out_nan_d  = out_nan;
    out_inf_d  = out_inf;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      flags_d = '0;
      count_d = '0;
    end else begin
      if (out_fire) begin
        state_d = ACCUM;
        acc_d   = '0;
        flags_d = '0;
        count_d = '0;
      end
      if (in_fire) begin
        if (count_q == CNT_W'(TERMS - 1)) begin
          state_d = HOLD;
          acc_d   = '0;
          flags_d = '0;
          count_d = '0;
          if (add_flags.nan || (add_flags.pinf && add_flags.ninf)) begin
            out_data_d = Q15_NAN;
            out_nan_d  = 1'b1;
            out_inf_d  = 1'b0;
          end else if (add_flags.pinf) begin
            out_data_d = Q15_POS_INF;
            out_nan_d  = 1'b0;
            out_inf_d  = 1'b1;
          end else if (add_flags.ninf) begin
            out_data_d = Q15_NEG_INF;
            out_nan_d  = 1'b0;
            out_inf_d  = 1'b1;
          end else begin
            out_data_d = add_acc;
            out_nan_d  = 1'b0;
            out_inf_d  = 1'b0;
          end
        end else begin
          acc_d   = add_acc;
          flags_d = add_flags;
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      flags_q  <= '0;
      count_q  <= '0;
      out_data <= '0;
      out_nan  <= 1'b0;
      out_inf  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
      out_data <= out_data_d;
      out_nan  <= out_nan_d;
      out_inf  <= out_inf_d;
    end
  end
endmodule

// File: tb/tb_q15_dot_accumulator.sv
// Directed and randomized checks of q15_dot_accumulator against a
// group-level reference model of the saturating sum.
module tb_q15_dot_accumulator;
  localparam int TERMS = 3;
  localparam logic [63:0] NANV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PINF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NINF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
  localparam longint MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint MINV = -64'sh7FFF_FFFF_FFFF_FFFF - 1;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic        out_nan, out_inf;
  logic [63:0] in_data, out_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] grp[$];
  bit          exp_valid;
  logic [63:0] exp_data;
  bit          exp_nan, exp_inf;

  q15_dot_accumulator #(.TERMS(TERMS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Group result straight from the arithmetic rules: specials are sticky,
  // any partial sum leaving the signed 64-bit range saturates that direction.
  function automatic void resolve_group();
    bit n = 0, p = 0, m = 0;
    longint sum = 0;
    longint tv;
    logic signed [127:0] w;
    foreach (grp[i]) begin
      if (grp[i] == NANV)      n = 1;
      else if (grp[i] == PINF) p = 1;
      else if (grp[i] == NINF) m = 1;
      else begin
        tv = grp[i];
        w  = sum;
        w  = w + tv;
        if (w > MAXV)      p = 1;
        else if (w < MINV) m = 1;
        else               sum = longint'(w);
      end
    end
    if (n || (p && m)) begin exp_data = NANV; exp_nan = 1; exp_inf = 0; end
    else if (p)        begin exp_data = PINF; exp_nan = 0; exp_inf = 1; end
    else if (m)        begin exp_data = NINF; exp_nan = 0; exp_inf = 1; end
    else               begin exp_data = sum;  exp_nan = 0; exp_inf = 0; end
  endfunction

  // Called at posedge+1; drives one cycle, steps the model, checks after the edge.
  task automatic cycle(input bit iv, input logic [63:0] d, input bit ordy,
                       input bit clr, input string tag);
    bit fire_in, fire_out;
    in_valid  = iv;
    in_data   = iv ? d : 64'hx;
    out_ready = ordy;
    clear     = clr;
    #1;
    check({tag, ":in_ready"}, 64'(in_ready), 64'(!exp_valid | ordy));
    fire_out = exp_valid & ordy;
    fire_in  = iv & (!exp_valid | ordy);
    if (clr) begin
      grp.delete();
      exp_valid = 0;
    end else begin
      if (fire_out) exp_valid = 0;
      if (fire_in) begin
        grp.push_back(d);
        if (grp.size() == TERMS) begin
          resolve_group();
          exp_valid = 1;
          grp.delete();
        end
      end
    end
    @(posedge clk); #1;
    check({tag, ":out_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check({tag, ":out_data"}, out_data, exp_data);
      check({tag, ":out_nan"}, 64'(out_nan), 64'(exp_nan));
      check({tag, ":out_inf"}, 64'(out_inf), 64'(exp_inf));
    end
    in_valid = 0;
    clear    = 0;
  endtask

  task automatic group3(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input string tag);
    cycle(1, a, 1, 0, tag);
    cycle(1, b, 1, 0, tag);
    cycle(1, c, 1, 0, tag);
    cycle(0, '0, 1, 0, {tag, ":drain"});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0; in_valid = 0; out_ready = 0; clear = 0;
    #1;
    check({tag, ":rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, ":rst_data"}, out_data, 64'd0);
    check({tag, ":rst_nan"}, 64'(out_nan), 64'd0);
    check({tag, ":rst_inf"}, 64'(out_inf), 64'd0);
    grp.delete();
    exp_valid = 0; exp_data = '0; exp_nan = 0; exp_inf = 0;
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    check({tag, ":rst_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_term();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       return NANV;
      1:       return PINF;
      2:       return NINF;
      3, 4:    return {$urandom, $urandom};
      5:       return {2'b01, 30'(r), 32'($urandom)};
      6:       return {2'b10, 30'(r), 32'($urandom)};
      default: return {{16{r[31]}}, r, 16'h0};
    endcase
  endfunction

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; out_ready = 0; in_data = '0;
    exp_valid = 0; exp_data = '0; exp_nan = 0; exp_inf = 0;
    do_reset("init");

    group3(ONE, 64'h0002_0000_0000_0000, 64'hFFFF_8000_0000_0000, "basic");
    group3(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
           64'hC000_0000_0000_0000, "ovf");
    group3(PINF, NINF, 64'h0, "pinf_ninf");
    group3(NANV, ONE, ONE, "nan");
    group3(NINF, ONE, ONE, "ninf");

    // Backpressure: result held for 4 cycles, then handoff with a new term.
    cycle(1, ONE, 1, 0, "bp");
    cycle(1, ONE, 1, 0, "bp");
    cycle(1, 64'h0005_0000_0000_0000, 0, 0, "bp");
    repeat (4) cycle(1, 64'h1234_0000_0000_0000, 0, 0, "bp_hold");
    cycle(1, ONE, 1, 0, "bp_swap");
    cycle(1, ONE, 1, 0, "bp_next");
    cycle(1, ONE, 1, 0, "bp_next");
    cycle(0, '0, 1, 0, "bp_drain");

    // Flush: clear discards partial sum and its same-edge term.
    cycle(1, ONE, 1, 0, "flush");
    cycle(1, ONE, 1, 0, "flush");
    cycle(1, 64'h0005_0000_0000_0000, 1, 1, "flush_clr");
    group3(ONE, ONE, ONE, "flush_after");

    // Reset in HOLD and mid-group.
    cycle(1, ONE, 1, 0, "rst_hold");
    cycle(1, ONE, 1, 0, "rst_hold");
    cycle(1, ONE, 0, 0, "rst_hold");
    do_reset("rst_in_hold");
    cycle(1, 64'h0007_0000_0000_0000, 1, 0, "rst_mid");
    do_reset("rst_in_mid");
    group3(ONE, 64'h0002_0000_0000_0000, ONE, "rst_after");

    repeat (600) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      cycle($urandom_range(0, 3) != 0, rand_term(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
